// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared opcode encodings and accumulate-FSM state type for
// the pipelined bitwise logic unit (logic_unit_pipe / logic_unit_core).
package logic_unit_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_ANDN  = 3'd4;
  localparam logic [2:0] OP_ORACC = 3'd5;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_BUSY = 1'b1
  } acc_state_e;

  // Opcodes 6 and 7 are reserved.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return op > OP_ORACC;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: purely combinational WIDTH-bit bitwise op select.
// Ports:
//   op  - 3-bit opcode (logic_unit_pkg encodings)
//   a,b - operands
//   y   - result; ORACC yields a|b (accumulation happens in the parent),
//         reserved opcodes yield 0.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_ANDN:  y = a & ~b;
      OP_ORACC: y = a | b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with one registered
// valid/ready output stage and a multi-beat OR-accumulate (ORACC) mode.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - input beat handshake
//   in_a, in_b, in_op   - operands and opcode
//   in_last             - final beat of an ORACC packet
//   out_valid/out_ready - result handshake
//   out_y               - result
//   out_beats           - beats folded into an ORACC result (1 otherwise)
//   out_zero/out_parity - result flags, present only when
//                         LOGIC_UNIT_FLAGS_EN is defined
//   out_illegal         - reserved opcode was issued
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_beats,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic             out_illegal
);

  acc_state_e       state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [WIDTH-1:0] core_y, res_y;
  logic [CNT_W-1:0] res_beats;
  logic             accept, is_oracc, produce;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op (in_op),
    .a  (in_a),
    .b  (in_b),
    .y  (core_y)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_oracc = (in_op == OP_ORACC);
  // ORACC non-last beats only fold into acc; everything else emits a result.
  assign produce  = accept && (!is_oracc || in_last);

  // Saturating beat count including the current beat.
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

  // acc/cnt are zero whenever the FSM is idle, so a single-beat packet
  // naturally gives a|b with one beat.
  assign res_y     = is_oracc ? (acc | core_y) : core_y;
  assign res_beats = is_oracc ? cnt_inc : CNT_W'(1);

  always_comb begin
    state_nxt = state;
    if (accept && is_oracc)
      state_nxt = in_last ? ACC_IDLE : ACC_BUSY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept && is_oracc) begin
        if (in_last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc | core_y;
          cnt <= cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_beats   <= '0;
      out_illegal <= 1'b0;
`ifdef LOGIC_UNIT_FLAGS_EN
      out_zero    <= 1'b0;
      out_parity  <= 1'b0;
`endif
    end else if (produce) begin
      // Covers the simultaneous pop+push case: new result replaces the old.
      out_valid   <= 1'b1;
      out_y       <= res_y;
      out_beats   <= res_beats;
      out_illegal <= op_is_illegal(in_op);
`ifdef LOGIC_UNIT_FLAGS_EN
      out_zero    <= (res_y == '0);
      out_parity  <= ^res_y;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] out_beats;
  logic             out_illegal;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             out_zero, out_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_beats   (out_beats),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero    (out_zero),
    .out_parity  (out_parity),
`endif
    .out_illegal (out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic last);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_last = last;
  endtask

  task automatic chk_res(input string tag, input logic [WIDTH-1:0] y, input logic [CNT_W-1:0] beats);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"},     64'(out_y), 64'(y));
    chk({tag, "_beats"}, 64'(out_beats), 64'(beats));
  endtask

  logic [WIDTH-1:0] exp_ops [5];

  initial begin
    exp_ops[0] = 32'h00F0_000F;
    exp_ops[1] = 32'hFFF0_0FFF;
    exp_ops[2] = 32'hFF00_0FF0;
    exp_ops[3] = 32'h000F_F000;
    exp_ops[4] = 32'hF000_00F0;

    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    step(); step();
    chk("rst_valid",   64'(out_valid), 64'd0);
    chk("rst_y",       64'(out_y), 64'd0);
    chk("rst_beats",   64'(out_beats), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Ops 0..4 back-to-back, latency 1.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
      step();
      chk_res($sformatf("op%0d", i), exp_ops[i], 8'd1);
      chk($sformatf("op%0d_illegal", i), 64'(out_illegal), 64'd0);
    end
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: hold one AND result, offer an OR beat.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    step();
    chk_res("bp_first", 32'h00F0_000F, 8'd1);
    drive(1'b1, 3'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("bp_hold_y", 64'(out_y), 64'h00F0_000F);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    chk_res("bp_pushpop", 32'hFFF0_0FFF, 8'd1);
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    step();
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // ORACC packet of three beats.
    drive(1'b1, 3'd5, 32'h1, 32'h2, 1'b0);
    step();
    chk("acc_b0_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 3'd5, 32'h10, 32'h0, 1'b0);
    step();
    chk("acc_b1_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 3'd5, 32'h0, 32'h8000_0000, 1'b1);
    step();
    chk_res("acc_pkt", 32'h8000_0013, 8'd3);
    drive(1'b1, 3'd5, 32'h0, 32'h0, 1'b1);
    step();
    chk_res("acc_single", 32'h0, 8'd1);
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    step();
    chk("acc_one_result", 64'(out_valid), 64'd0);

    // Interleaved XOR inside an ORACC packet.
    drive(1'b1, 3'd5, 32'h4, 32'h0, 1'b0);
    step();
    chk("il_b0_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 3'd2, 32'hA, 32'h3, 1'b0);
    step();
    chk_res("il_xor", 32'h9, 8'd1);
    drive(1'b1, 3'd5, 32'h1, 32'h0, 1'b1);
    step();
    chk_res("il_acc", 32'h5, 8'd2);

    // Reserved opcodes.
    drive(1'b1, 3'd6, 32'hFF, 32'hFF, 1'b0);
    step();
    chk_res("ill6", 32'h0, 8'd1);
    chk("ill6_flag", 64'(out_illegal), 64'd1);
    drive(1'b1, 3'd7, 32'h1, 32'h1, 1'b1);
    step();
    chk_res("ill7", 32'h0, 8'd1);
    chk("ill7_flag", 64'(out_illegal), 64'd1);

    // Reset mid-packet discards the partial accumulation.
    drive(1'b1, 3'd5, 32'h100, 32'h0, 1'b0);
    step(); step();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mrst_valid",   64'(out_valid), 64'd0);
    chk("mrst_y",       64'(out_y), 64'd0);
    chk("mrst_beats",   64'(out_beats), 64'd0);
    chk("mrst_illegal", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 3'd5, 32'h2, 32'h0, 1'b1);
    step();
    chk_res("mrst_after", 32'h2, 8'd1);

    // Beat counter saturates at all-ones.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd5, 32'(1) << (i % 32), 32'h0, 1'b0);
      step();
    end
    drive(1'b1, 3'd5, 32'h0, 32'h0, 1'b1);
    step();
    chk_res("sat", 32'hFFFF_FFFF, 8'hFF);

`ifdef LOGIC_UNIT_FLAGS_EN
    drive(1'b1, 3'd0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    step();
    chk("flg_and_zero",   64'(out_zero), 64'd1);
    chk("flg_and_parity", 64'(out_parity), 64'd0);
    drive(1'b1, 3'd1, 32'h7, 32'h0, 1'b0);
    step();
    chk("flg_or_zero",   64'(out_zero), 64'd0);
    chk("flg_or_parity", 64'(out_parity), 64'd1);
`endif

    drive(1'b0, 3'd0, '0, '0, 1'b0);
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit for the ALU datapath, generalising the fixed 32-bit OR stage. It takes two WIDTH-bit operands and an opcode, and selects one of five bitwise operations or an OR-accumulate across a multi-beat packet. The result is returned through a one-stage registered valid/ready pipeline. It sits beside the adder and shifter, feeding the ALU result mux.

## Interface
- WIDTH, 32, operand/result width (≥1)
- CNT_W, 8, width of the accumulate beat counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  opcode (see Operation)
- in_last  in  1  final beat of an ORACC packet; ignored for other ops
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result when out_valid & out_ready
- out_y  out  WIDTH  result
- out_beats  out  CNT_W  beats folded into an ORACC result (1 for other ops)
- out_illegal  out  1  reserved opcode was issued
- out_zero, out_parity  out  1 each  flags (only with LOGIC_UNIT_FLAGS_EN)

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN (a & ~b), 5 ORACC, 6–7 reserved.
- Reserved opcodes produce a result with out_y=0, out_illegal=1, out_beats=1.
- Ops 0–4: one accepted beat produces one result. The accumulator and counter are untouched.
- ORACC uses a two-state machine: ACC_IDLE and ACC_BUSY. Registers: acc[WIDTH] and cnt[CNT_W].
  - Accepted ORACC beat with in_last=0: acc ← acc | a | b, cnt ← cnt+1 (saturating at all-ones). State → ACC_BUSY. No result is produced.
  - Accepted ORACC beat with in_last=1: result out_y = acc | a | b, out_beats = cnt+1 (saturating). Then acc ← 0, cnt ← 0, state → ACC_IDLE.
  - A single-beat packet (in_last=1 from ACC_IDLE) gives a | b with out_beats=1.
  - Non-ORACC beats accepted in ACC_BUSY are processed normally. The accumulation is held and resumes on the next ORACC beat.
- Handshake: in_ready = !out_valid | out_ready. This is combinational and independent of opcode.
- Output register loads only on acceptance of a result-producing beat. It holds stable while out_valid & !out_ready.
- Reset (rst_n=0 at an edge) takes priority over everything:
  - out_valid=0, out_y=0, out_beats=0, out_illegal=0, flags=0.
  - acc=0, cnt=0, state ACC_IDLE.
  - An in-flight result or partial accumulation is discarded.

## Timing
- Latency: a beat accepted at edge N shows its result with out_valid=1 after edge N.
- Throughput: one beat per cycle when out_ready is held high.
- Simultaneous output pop and input push in the same cycle: the new result replaces the old one. No bubble is inserted.
- When out_valid=0, no result-producing beat is accepted, and out_ready is low: out_valid stays 0.
- in_ready is low only when out_valid=1 and out_ready=0. ORACC non-last beats also stall in that case.

## Configuration
- LOGIC_UNIT_FLAGS_EN defined: out_zero = (result == 0) and out_parity = ^result are registered with out_y and cleared by reset.
- Not defined: the out_zero and out_parity ports do not exist and no flag logic is built.

## Structure
- Shared package logic_unit_pkg holds:
  - opcode localparams OP_AND…OP_ORACC
  - state encoding ACC_IDLE/ACC_BUSY
- Sub-module logic_unit_core: purely combinational WIDTH-bit op select (ops 0–4, plus OR for ORACC), instantiated once. The top holds the FSM, accumulator and output register.

## Test plan
- Reset and ops: WIDTH=32, out_ready=1.
  - a=0xF0F0_00FF, b=0x0FF0_0F0F for ops 0–4, back-to-back.
  - Required results: 0x00F0_000F, 0xFFF0_0FFF, 0xFF00_0FF0, 0x000F_F000, 0xF000_00F0, one per cycle, latency 1, out_beats=1.
- Backpressure: out_ready=0 with one result held.
  - in_ready=0, and out_y stays stable for 5 cycles.
  - Raising out_ready with in_valid=1 gives a pop and push in the same cycle, with no lost or duplicated beat.
- ORACC packet: beats (a,b) = (0x1,0x2), (0x10,0), (0,0x8000_0000, last).
  - Exactly one result: out_y=0x8000_0013, out_beats=3.
  - A following single-beat ORACC with a=b=0 gives 0, out_beats=1.
- Interleave: ORACC beat 0x4 (not last), then XOR beat 0xA^0x3, then ORACC 0x1 (last).
  - Results: 0x9 then 0x5, out_beats 1 then 2.
- Illegal and reset: op=6 gives out_illegal=1, out_y=0.
  - rst_n=0 for one cycle mid-packet after 2 ORACC beats: all outputs 0.
  - The next ORACC last beat a=0x2, b=0 gives 0x2, out_beats=1.
- Flags (LOGIC_UNIT_FLAGS_EN defined):
  - AND of 0xFFFF_0000 and 0x0000_FFFF gives out_zero=1, out_parity=0.
  - OR of 0x7 and 0 gives out_zero=0, out_parity=1.
